// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: default field width, unused-Tuse code, forwarding stage indices.
// Latency: n/a (constants only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

  // Default width of the Tuse/Tnew decode fields.
  localparam int T_W_DEF   = 3;

  // Tuse code the decoder emits for an operand the instruction never reads.
  localparam int TUSE_NONE = 4;

  // Forwarding select values: register file, then shadow stages E, M, W.
  localparam int FS_RF     = 0;
  localparam int FS_E      = 1;
  localparam int FS_M      = 2;
  localparam int FS_W      = 3;

endpackage

// File: rtl/hazard_scoreboard_sat_dec_shift.sv
// One shadow-pipeline stage: holds an in-flight producer {dst, tnew, hilo_start}.
// Latency: 1 cycle; tnew is decremented (saturating at 0) as it is captured.
// Backpressure: none, captures every edge; reset or clear_i zeroes the entry.
module hazard_scoreboard_sat_dec_shift
  import hazard_scoreboard_pkg::*;
#(
  parameter int T_W = T_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear_i,
  input  logic [4:0]     dst_i,
  input  logic [T_W-1:0] tnew_i,
  input  logic           hilo_i,
  output logic [4:0]     dst_o,
  output logic [T_W-1:0] tnew_o,
  output logic           hilo_o
);

  logic [4:0]     dst_q;
  logic [T_W-1:0] tnew_q;
  logic [T_W-1:0] tnew_d;
  logic           hilo_q;

  // Count one cycle closer to availability; a ready result stays at 0.
  always_comb begin
    tnew_d = (tnew_i == '0) ? '0 : tnew_i - T_W'(1);
  end

  // Shift the producer in every edge; reset and flush both kill it.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      dst_q  <= 5'd0;
      tnew_q <= '0;
      hilo_q <= 1'b0;
    end else begin
      dst_q  <= dst_i;
      tnew_q <= tnew_d;
      hilo_q <= hilo_i;
    end
  end

  assign dst_o  = dst_q;
  assign tnew_o = tnew_q;
  assign hilo_o = hilo_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard: tracks in-flight producers after D, drives stall and operand forwarding selects.
// Latency: stall/fwd are combinational on D-stage fields; shadow state advances one stage per edge.
// Backpressure: stall freezes PC and F/D and turns the E load into a bubble; the shadow pipe itself never stalls.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES      = 3,
  parameter int T_W         = T_W_DEF,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int FS_W        = $clog2(STAGES + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            d_valid,
  input  logic [4:0]      d_rs,
  input  logic [4:0]      d_rt,
  input  logic [T_W-1:0]  d_tuse_rs,
  input  logic [T_W-1:0]  d_tuse_rt,
  input  logic            d_regwrite,
  input  logic [4:0]      d_dst,
  input  logic [T_W-1:0]  d_tnew,
  input  logic            d_ishilo,
  input  logic            d_muldiv,
  input  logic            d_isdiv,
  output logic            stall,
  output logic [FS_W-1:0] fwd_rs,
  output logic [FS_W-1:0] fwd_rt,
  output logic            muldiv_busy,
  output logic [T_W-1:0]  e_tnew
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Shadow entries, index 1 = E.
  logic [4:0]       dst_q  [1:STAGES];
  logic [T_W-1:0]   tnew_q [1:STAGES];
  logic             hilo_q [1:STAGES];

  logic             accept;
  logic [4:0]       ld_dst;
  logic [T_W-1:0]   ld_tnew;
  logic             ld_hilo;
  logic             data_hz;
  logic             hilo_hz;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // An instruction leaves D only when it is real, not held back and not being flushed.
  assign accept = d_valid & ~stall & ~flush;

  // Build the E-stage entry; anything not accepted enters as an all-zero bubble.
  always_comb begin
    ld_dst  = (accept & d_regwrite) ? d_dst : 5'd0;
    ld_tnew = accept ? d_tnew : '0;
    ld_hilo = accept & d_muldiv;
  end

  for (genvar g = 1; g <= STAGES; g++) begin : g_stage
    if (g == 1) begin : g_head
      hazard_scoreboard_sat_dec_shift #(.T_W(T_W)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .dst_i   (ld_dst),
        .tnew_i  (ld_tnew),
        .hilo_i  (ld_hilo),
        .dst_o   (dst_q[g]),
        .tnew_o  (tnew_q[g]),
        .hilo_o  (hilo_q[g])
      );
    end else begin : g_tail
      hazard_scoreboard_sat_dec_shift #(.T_W(T_W)) u_stage (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .dst_i   (dst_q[g-1]),
        .tnew_i  (tnew_q[g-1]),
        .hilo_i  (hilo_q[g-1]),
        .dst_o   (dst_q[g]),
        .tnew_o  (tnew_q[g]),
        .hilo_o  (hilo_q[g])
      );
    end
  end

  // Data hazard: a producer of a read operand whose result lands later than the operand is needed.
  // Tuse values at or beyond STAGES mark an operand the instruction does not read.
  always_comb begin
    data_hz = 1'b0;
    for (int i = 1; i <= STAGES; i++) begin
      if (dst_q[i] != 5'd0) begin
        if (dst_q[i] == d_rs && int'(d_tuse_rs) < STAGES && tnew_q[i] > d_tuse_rs) data_hz = 1'b1;
        if (dst_q[i] == d_rt && int'(d_tuse_rt) < STAGES && tnew_q[i] > d_tuse_rt) data_hz = 1'b1;
      end
    end
  end

  assign hilo_hz = d_ishilo & muldiv_busy;
  assign stall   = d_valid & (data_hz | hilo_hz);

  // Forward from the youngest stage holding a ready result; scanning oldest-first lets younger ones override.
  always_comb begin
    fwd_rs = FS_W'(FS_RF);
    fwd_rt = FS_W'(FS_RF);
    for (int i = STAGES; i >= 1; i--) begin
      if (dst_q[i] != 5'd0 && tnew_q[i] == '0) begin
        if (dst_q[i] == d_rs) fwd_rs = FS_W'(i);
        if (dst_q[i] == d_rt) fwd_rt = FS_W'(i);
      end
    end
  end

  // Mul/div occupancy: load on issue into E, otherwise count down to idle.
  always_comb begin
    cnt_d = cnt_q;
    if (accept & d_muldiv) begin
      cnt_d = d_isdiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Busy counter survives flush so an already issued mul/div still completes.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign muldiv_busy = (cnt_q != '0);
  assign e_tnew      = tnew_q[1];

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios then random traffic against an in-flight list model.
// Latency: outputs sampled 1 time unit after the input-drive edge (negedge), state advances at posedge.
// Backpressure: model honours its own predicted stall when deciding what enters E.
module tb_hazard_scoreboard;

  localparam int STAGES      = 3;
  localparam int T_W         = 3;
  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int FS_W        = 2;
  localparam int TNONE       = hazard_scoreboard_pkg::TUSE_NONE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, flush, d_valid, d_regwrite, d_ishilo, d_muldiv, d_isdiv;
  logic [4:0]      d_rs, d_rt, d_dst;
  logic [T_W-1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic            stall, muldiv_busy;
  logic [FS_W-1:0] fwd_rs, fwd_rt;
  logic [T_W-1:0]  e_tnew;

  hazard_scoreboard #(
    .STAGES(STAGES), .T_W(T_W), .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .FS_W(FS_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_regwrite(d_regwrite), .d_dst(d_dst), .d_tnew(d_tnew),
    .d_ishilo(d_ishilo), .d_muldiv(d_muldiv), .d_isdiv(d_isdiv),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .muldiv_busy(muldiv_busy), .e_tnew(e_tnew)
  );

  // Reference model: list of issued instructions with the cycle they entered E.
  typedef struct {int issue; int dst; int tnew;} prod_t;
  prod_t pq[$];
  int cyc        = 0;
  int busy_until = -1;
  int total      = 0;
  int bad        = 0;

  logic            obs_stall, obs_busy;
  logic [FS_W-1:0] obs_frs, obs_frt;
  logic [T_W-1:0]  obs_et;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs for the current cycle, from ages and remaining latency of in-flight producers.
  task automatic model_eval(output logic e_stall, output int e_frs, output int e_frt,
                            output int e_et, output logic e_busy);
    bit hz;
    int age, rem;
    hz = 0; e_frs = 0; e_frt = 0; e_et = 0;
    e_busy = (cyc <= busy_until);
    foreach (pq[k]) begin
      age = cyc - pq[k].issue;
      rem = (pq[k].tnew > age) ? pq[k].tnew - age : 0;
      if (age == 1) e_et = rem;
      if (pq[k].dst != 0) begin
        if (pq[k].dst == int'(d_rs) && int'(d_tuse_rs) < STAGES && rem > int'(d_tuse_rs)) hz = 1;
        if (pq[k].dst == int'(d_rt) && int'(d_tuse_rt) < STAGES && rem > int'(d_tuse_rt)) hz = 1;
        if (pq[k].dst == int'(d_rs) && rem == 0 && (e_frs == 0 || age < e_frs)) e_frs = age;
        if (pq[k].dst == int'(d_rt) && rem == 0 && (e_frt == 0 || age < e_frt)) e_frt = age;
      end
    end
    e_stall = d_valid && (hz || (d_ishilo && e_busy));
  endtask

  task automatic commit(input logic e_stall);
    prod_t p;
    if (reset) begin
      pq.delete();
      busy_until = -1;
    end else if (flush) begin
      pq.delete();
    end else if (d_valid && !e_stall) begin
      p.issue = cyc;
      p.dst   = d_regwrite ? int'(d_dst) : 0;
      p.tnew  = int'(d_tnew);
      pq.push_back(p);
      if (d_muldiv) busy_until = cyc + (d_isdiv ? DIV_CYCLES : MULT_CYCLES);
    end
    cyc++;
    while (pq.size() > 0 && cyc - pq[0].issue > STAGES) void'(pq.pop_front());
  endtask

  // Inputs are already driven (just after negedge); sample, compare, advance one clock.
  task automatic step();
    logic es, eb;
    int efr, eft, eet;
    #1;
    obs_stall = stall; obs_busy = muldiv_busy; obs_frs = fwd_rs; obs_frt = fwd_rt; obs_et = e_tnew;
    es = 1'b0;
    if (!reset) begin
      model_eval(es, efr, eft, eet, eb);
      chk("stall",  stall,       es);
      chk("fwd_rs", fwd_rs,      efr);
      chk("fwd_rt", fwd_rt,      eft);
      chk("busy",   muldiv_busy, eb);
      chk("e_tnew", e_tnew,      eet);
    end
    commit(es);
    @(negedge clk);
  endtask

  task automatic idle();
    d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = T_W'(TNONE); d_tuse_rt = T_W'(TNONE);
    d_regwrite = 0; d_dst = 0; d_tnew = 0; d_ishilo = 0; d_muldiv = 0; d_isdiv = 0;
  endtask

  task automatic instr(input int rs, input int rt, input int tur, input int tut,
                       input logic rw, input int dst, input int tn);
    idle();
    d_valid = 1; d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = T_W'(tur); d_tuse_rt = T_W'(tut);
    d_regwrite = rw; d_dst = 5'(dst); d_tnew = T_W'(tn);
  endtask

  task automatic drain(input int n);
    idle();
    for (int k = 0; k < n; k++) step();
  endtask

  int n;

  initial begin
    idle(); reset = 1; flush = 0;
    @(negedge clk);
    step(); step();
    reset = 0;
    step();
    chk("rst_stall", obs_stall, 0); chk("rst_busy", obs_busy, 0);
    chk("rst_fwd_rs", obs_frs, 0);  chk("rst_fwd_rt", obs_frt, 0); chk("rst_e_tnew", obs_et, 0);

    // lw $8 (result 3 cycles after D) then addu $9,$8,$8
    instr(29, 0, 1, TNONE, 1, 8, 3); step();
    instr(8, 8, 1, 1, 1, 9, 1);      step();
    chk("lw_use_stall", obs_stall, 1);
    step();
    chk("lw_use_release", obs_stall, 0); chk("lw_use_fwd_notready", obs_frs, 0);
    drain(4);

    // addu $8 then beq $8,$0
    instr(1, 2, 1, 1, 1, 8, 2); step();
    instr(8, 0, 0, 0, 0, 0, 0); step();
    chk("beq_stall", obs_stall, 1);
    step();
    chk("beq_release", obs_stall, 0); chk("beq_fwd_rs", obs_frs, 2); chk("beq_fwd_rt", obs_frt, 0);
    drain(4);

    // ori $5 twice, then sw using $5: youngest producer wins
    instr(0, 0, 1, TNONE, 1, 5, 1); step();
    instr(0, 0, 1, TNONE, 1, 5, 1); step();
    instr(4, 5, 1, 2, 0, 0, 0);     step();
    chk("sw_youngest_fwd_rt", obs_frt, 1); chk("sw_no_stall", obs_stall, 0);
    drain(4);

    // div then mfhi: held for the whole divide, mult then mfhi likewise
    for (int m = 0; m < 2; m++) begin
      instr(2, 3, 1, 1, 0, 0, 1); d_ishilo = 1; d_muldiv = 1; d_isdiv = (m == 0); step();
      instr(0, 0, TNONE, TNONE, 1, 7, 2); d_ishilo = 1;
      n = 0;
      for (int k = 0; k < 20; k++) begin
        step();
        if (obs_stall) n++;
        else break;
      end
      chk(m == 0 ? "div_stall_cycles" : "mult_stall_cycles", n, m == 0 ? DIV_CYCLES : MULT_CYCLES);
      drain(4);
    end

    // writer to $0 followed by reader of $0
    instr(1, 2, 1, 1, 1, 0, 2); step();
    instr(0, 0, 0, 0, 1, 9, 1); step();
    chk("r0_stall", obs_stall, 0); chk("r0_fwd_rs", obs_frs, 0); chk("r0_fwd_rt", obs_frt, 0);
    drain(4);

    // flush with lw $8 in E and a dependent reader in D
    instr(29, 0, 1, TNONE, 1, 8, 3); step();
    instr(8, 0, 1, TNONE, 1, 9, 1); flush = 1; step();
    flush = 0; step();
    chk("flush_stall", obs_stall, 0); chk("flush_fwd_rs", obs_frs, 0); chk("flush_e_tnew", obs_et, 0);
    drain(4);

    // reset while the divide counter is at 6
    instr(2, 3, 1, 1, 0, 0, 1); d_ishilo = 1; d_muldiv = 1; d_isdiv = 1; step();
    drain(4);
    reset = 1; step();
    chk("busy_at6", obs_busy, 1);
    reset = 0; step();
    chk("busy_after_reset", obs_busy, 0);

    // random traffic over a small register set to provoke hazards
    for (int k = 0; k < 3000; k++) begin
      d_valid    = 1'($urandom_range(0, 9) < 8);
      d_rs       = 5'($urandom_range(0, 3));
      d_rt       = 5'($urandom_range(0, 3));
      d_dst      = 5'($urandom_range(0, 3));
      d_tuse_rs  = T_W'($urandom_range(0, 4));
      d_tuse_rt  = T_W'($urandom_range(0, 4));
      d_tnew     = T_W'($urandom_range(0, 5));
      d_regwrite = 1'($urandom_range(0, 1));
      d_muldiv   = 1'($urandom_range(0, 15) == 0);
      d_ishilo   = d_muldiv | 1'($urandom_range(0, 7) == 0);
      d_isdiv    = d_muldiv & 1'($urandom_range(0, 1));
      flush      = 1'($urandom_range(0, 24) == 0);
      reset      = 1'($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0; flush = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
